// File: rtl/beep_pkg.sv
// Shared definitions for the melody sequencer: FSM encoding and special note codes.
package beep_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StWait,
    StPlay,
    StPaused
  } state_e;

  localparam logic [7:0] END_MARKER = 8'hFF;
  localparam logic [7:0] REST_NOTE  = 8'h00;

endpackage

// File: rtl/beat_timer.sv
// Beat position counter with end-of-beat and muted-gap flags.
module beat_timer #(
  parameter int unsigned BEAT_CYCLES = 16777216,
  parameter int unsigned GAP_CYCLES  = 65536
) (
  input  logic        clk,
  input  logic        clear,
  input  logic        enable,
  output logic [23:0] cnt,
  output logic        beat_end,
  output logic        in_gap
);

  localparam logic [31:0] BeatLast  = BEAT_CYCLES - 1;
  localparam logic [31:0] PlayLimit = BEAT_CYCLES - GAP_CYCLES;

  always_ff @(posedge clk) begin
    if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 24'd1;
    end
  end

  assign beat_end = ({8'd0, cnt} == BeatLast);
  assign in_gap   = ({8'd0, cnt} >= PlayLimit);

endmodule

// File: rtl/melody_sequencer.sv
// Steps through a synchronous music ROM one beat per entry, driving a tone generator.
module melody_sequencer
  import beep_pkg::*;
#(
  parameter int unsigned BEAT_CYCLES = 16777216,
  parameter int unsigned GAP_CYCLES  = 65536
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       pause,
  input  logic       loop_en,
  output logic [7:0] rom_addr,
  input  logic [7:0] rom_note,
  output logic [7:0] note_out,
  output logic       note_valid,
  output logic       busy,
  output logic       done
);

  localparam logic [31:0] PlayLimit = BEAT_CYCLES - GAP_CYCLES;

  state_e      state;
  logic [23:0] beat_cnt;
  logic        beat_end;
  logic        in_gap;
  logic        gap_next;
  logic        tmr_clear;
  logic        tmr_enable;

  // The PLAY cycle that sees pause still consumes its count; only PAUSED holds it.
  assign tmr_clear  = rst || (state == StIdle) || (state == StWait);
  assign tmr_enable = (state == StPlay) && !stop && !beat_end;

  // note_valid is registered, so it looks one count ahead.
  assign gap_next = (({8'd0, beat_cnt} + 32'd1) >= PlayLimit);

  beat_timer #(
    .BEAT_CYCLES(BEAT_CYCLES),
    .GAP_CYCLES (GAP_CYCLES)
  ) u_timer (
    .clk     (clk),
    .clear   (tmr_clear),
    .enable  (tmr_enable),
    .cnt     (beat_cnt),
    .beat_end(beat_end),
    .in_gap  (in_gap)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= StIdle;
      rom_addr   <= 8'd0;
      note_out   <= 8'd0;
      note_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop && (state != StIdle)) begin
        state      <= StIdle;
        note_valid <= 1'b0;
        busy       <= 1'b0;
      end else begin
        unique case (state)
          StIdle: begin
            if (start && !stop) begin
              rom_addr <= 8'd0;
              state    <= StFetch;
              busy     <= 1'b1;
            end
          end
          StFetch: state <= StWait;
          StWait: begin
            if (rom_note == END_MARKER) begin
              // Looping from address 0 onto a marker would spin forever; finish instead.
              if (loop_en && (rom_addr != 8'd0)) begin
                rom_addr <= 8'd0;
                state    <= StFetch;
              end else begin
                state <= StIdle;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end else begin
              note_out   <= rom_note;
              note_valid <= (rom_note != REST_NOTE);
              state      <= StPlay;
            end
          end
          StPlay: begin
            if (beat_end) begin
              note_valid <= 1'b0;
              if ((rom_addr == 8'hFF) && !loop_en) begin
                state <= StIdle;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                rom_addr <= rom_addr + 8'd1;
                state    <= StFetch;
              end
            end else if (pause) begin
              note_valid <= 1'b0;
              state      <= StPaused;
            end else begin
              note_valid <= (note_out != REST_NOTE) && !gap_next;
            end
          end
          StPaused: begin
            if (!pause) begin
              note_valid <= (note_out != REST_NOTE) && !in_gap;
              state      <= StPlay;
            end
          end
          default: begin
            state      <= StIdle;
            note_valid <= 1'b0;
            busy       <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench for melody_sequencer with an 8-cycle beat and 2-cycle gap.
module tb_melody_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       pause = 1'b0;
  logic       loop_en = 1'b0;
  logic [7:0] rom_addr;
  logic [7:0] rom_note = 8'd0;
  logic [7:0] note_out;
  logic       note_valid;
  logic       busy;
  logic       done;

  logic [7:0] rom_mem [256];

  int ncmp = 0;
  int nerr = 0;

  melody_sequencer #(
    .BEAT_CYCLES(8),
    .GAP_CYCLES (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .pause     (pause),
    .loop_en   (loop_en),
    .rom_addr  (rom_addr),
    .rom_note  (rom_note),
    .note_out  (note_out),
    .note_valid(note_valid),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: data follows the address by one clock.
  always @(posedge clk) rom_note <= rom_mem[rom_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic [7:0] addr, input logic nv,
                         input logic bsy, input logic dn);
    chk({tag, " addr"}, 32'(rom_addr), 32'(addr));
    chk({tag, " valid"}, 32'(note_valid), 32'(nv));
    chk({tag, " busy"}, 32'(busy), 32'(bsy));
    chk({tag, " done"}, 32'(done), 32'(dn));
  endtask

  // Checks the 8 PLAY cycles of one beat; ends on the following FETCH cycle.
  task automatic play_beat(input logic [7:0] note, input logic [7:0] addr, input int hi);
    for (int j = 0; j < 8; j++) begin
      chk($sformatf("a%0d j%0d note", addr, j), 32'(note_out), 32'(note));
      chk_ctl($sformatf("a%0d j%0d", addr, j), addr, (j < hi), 1'b1, 1'b0);
      tick();
    end
  endtask

  // Pulses start and walks through FETCH and WAIT into the first PLAY cycle.
  task automatic kick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_ctl("fetch0", 8'd0, 1'b0, 1'b1, 1'b0);
    tick();
    chk_ctl("wait0", 8'd0, 1'b0, 1'b1, 1'b0);
    tick();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom_mem[i] = 8'd0;
    rom_mem[0] = 8'd25;
    rom_mem[1] = 8'd27;
    rom_mem[2] = 8'hFF;

    // Reset state
    tick();
    tick();
    rst = 1'b0;
    chk_ctl("reset", 8'd0, 1'b0, 1'b0, 1'b0);
    chk("reset note", 32'(note_out), 32'd0);
    chk("reset cnt", 32'(dut.u_timer.cnt), 32'd0);

    // Basic song with end marker
    kick();
    play_beat(8'd25, 8'd0, 6);
    chk_ctl("t1 fetch1", 8'd1, 1'b0, 1'b1, 1'b0);
    tick();
    tick();
    play_beat(8'd27, 8'd1, 6);
    chk_ctl("t1 fetch2", 8'd2, 1'b0, 1'b1, 1'b0);
    tick();
    tick();
    chk_ctl("t1 end", 8'd2, 1'b0, 1'b0, 1'b1);
    tick();
    chk_ctl("t1 after", 8'd2, 1'b0, 1'b0, 1'b0);
    start = 1'b0;

    // Looping: marker at address 2 returns to 0 without done
    loop_en = 1'b1;
    kick();
    play_beat(8'd25, 8'd0, 6);
    tick();
    tick();
    play_beat(8'd27, 8'd1, 6);
    chk_ctl("t2 fetch2", 8'd2, 1'b0, 1'b1, 1'b0);
    tick();
    tick();
    chk_ctl("t2 loop", 8'd0, 1'b0, 1'b1, 1'b0);
    tick();
    tick();
    play_beat(8'd25, 8'd0, 6);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    loop_en = 1'b0;
    chk_ctl("t2 stop", 8'd1, 1'b0, 1'b0, 1'b0);

    // Rest note keeps note_valid low for the whole beat
    rom_mem[1] = 8'd0;
    kick();
    play_beat(8'd25, 8'd0, 6);
    tick();
    tick();
    play_beat(8'd0, 8'd1, 0);
    tick();
    tick();
    chk_ctl("t3 end", 8'd2, 1'b0, 1'b0, 1'b1);
    rom_mem[1] = 8'd27;

    // Pause for 3 cycles at beat_cnt 4 stretches the beat to 11 cycles
    tick();
    kick();
    for (int j = 0; j < 4; j++) begin
      chk_ctl($sformatf("t4 j%0d", j), 8'd0, 1'b1, 1'b1, 1'b0);
      tick();
    end
    chk("t4 cnt4", 32'(dut.u_timer.cnt), 32'd4);
    chk_ctl("t4 j4", 8'd0, 1'b1, 1'b1, 1'b0);
    pause = 1'b1;
    tick();
    chk_ctl("t4 p1", 8'd0, 1'b0, 1'b1, 1'b0);
    chk("t4 p1 cnt", 32'(dut.u_timer.cnt), 32'd5);
    tick();
    chk_ctl("t4 p2", 8'd0, 1'b0, 1'b1, 1'b0);
    tick();
    pause = 1'b0;
    chk_ctl("t4 p3", 8'd0, 1'b0, 1'b1, 1'b0);
    chk("t4 p3 cnt", 32'(dut.u_timer.cnt), 32'd5);
    tick();
    chk_ctl("t4 j5", 8'd0, 1'b1, 1'b1, 1'b0);
    tick();
    chk_ctl("t4 j6", 8'd0, 1'b0, 1'b1, 1'b0);
    tick();
    chk_ctl("t4 j7", 8'd0, 1'b0, 1'b1, 1'b0);
    tick();
    chk_ctl("t4 fetch1", 8'd1, 1'b0, 1'b1, 1'b0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk_ctl("t4 stop", 8'd1, 1'b0, 1'b0, 1'b0);

    // Stop together with pause at beat_cnt 3 of address 1
    kick();
    play_beat(8'd25, 8'd0, 6);
    tick();
    tick();
    for (int j = 0; j < 3; j++) begin
      chk_ctl($sformatf("t5 j%0d", j), 8'd1, 1'b1, 1'b1, 1'b0);
      tick();
    end
    chk("t5 cnt3", 32'(dut.u_timer.cnt), 32'd3);
    stop = 1'b1;
    pause = 1'b1;
    tick();
    stop = 1'b0;
    pause = 1'b0;
    chk_ctl("t5 stopped", 8'd1, 1'b0, 1'b0, 1'b0);
    for (int j = 0; j < 3; j++) begin
      tick();
      chk_ctl($sformatf("t5 idle%0d", j), 8'd1, 1'b0, 1'b0, 1'b0);
    end
    kick();
    chk("t5 replay note", 32'(note_out), 32'd25);
    chk_ctl("t5 replay", 8'd0, 1'b1, 1'b1, 1'b0);
    stop = 1'b1;
    tick();
    stop = 1'b0;

    // Full ROM of notes: done after address 255, no wrap
    for (int i = 0; i < 256; i++) rom_mem[i] = 8'd25;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int a = 0; a < 256; a++) begin
      chk_ctl($sformatf("t6 fetch%0d", a), 8'(a), 1'b0, 1'b1, 1'b0);
      tick();
      tick();
      play_beat(8'd25, 8'(a), 6);
    end
    chk_ctl("t6 end", 8'd255, 1'b0, 1'b0, 1'b1);
    tick();
    chk_ctl("t6 after", 8'd255, 1'b0, 1'b0, 1'b0);

    // Reset mid-beat while paused, with start held
    kick();
    tick();
    tick();
    pause = 1'b1;
    tick();
    chk_ctl("t7 paused", 8'd0, 1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    start = 1'b1;
    tick();
    chk_ctl("t7 rst", 8'd0, 1'b0, 1'b0, 1'b0);
    chk("t7 rst note", 32'(note_out), 32'd0);
    chk("t7 rst cnt", 32'(dut.u_timer.cnt), 32'd0);
    rst = 1'b0;
    start = 1'b0;
    pause = 1'b0;
    tick();
    chk_ctl("t7 idle", 8'd0, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/melody_sequencer.md
MELODY_SEQUENCER -- requirements
Module: melody_sequencer

Interface
REQ-001 The block SHALL provide parameter BEAT_CYCLES, default 16777216, giving clk cycles per ROM entry (one beat).
REQ-002 The block SHALL provide parameter GAP_CYCLES, default 65536, giving muted cycles at the end of each beat; legal range 0 to BEAT_CYCLES-1.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  level; sampled in IDLE only, begins playback at address 0.
REQ-006 stop  input  1  level; aborts playback from any state.
REQ-007 pause  input  1  level; holds playback while high.
REQ-008 loop_en  input  1  level; restarts at address 0 on end of song instead of finishing.
REQ-009 rom_addr  output  8  registered address to the music ROM.
REQ-010 rom_note  input  8  ROM data, valid one cycle after rom_addr changes (synchronous ROM).
REQ-011 note_out  output  8  registered note code to the tone generator.
REQ-012 note_valid  output  1  tone generator enable; low means silence.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse on natural end of song.

Function
REQ-015 The FSM SHALL have states IDLE, FETCH, WAIT, PLAY, PAUSED.
REQ-016 IDLE, start=1, stop=0: rom_addr<=0, next FETCH; start while busy SHALL be ignored.
REQ-017 FETCH SHALL last exactly one cycle, then WAIT.
REQ-018 In WAIT, rom_note==8'hFF (end marker) SHALL end the song: loop_en=1 and rom_addr!=0 -> rom_addr<=0, FETCH; otherwise -> IDLE with done=1 for one cycle.
REQ-019 In WAIT, any other rom_note SHALL be latched into note_out, beat_cnt<=0, next PLAY.
REQ-020 Latency: start sampled at edge k -> FETCH k+1, WAIT k+2, PLAY with note_valid k+3.
REQ-021 In PLAY, beat_cnt SHALL increment by 1 per cycle from 0 to BEAT_CYCLES-1.
REQ-022 note_valid SHALL be 1 only in PLAY with note_out!=0 and beat_cnt < BEAT_CYCLES-GAP_CYCLES; code 0 is a rest.
REQ-023 At beat_cnt==BEAT_CYCLES-1: rom_addr==255 and loop_en=0 -> IDLE with done pulse; otherwise rom_addr<=rom_addr+1 (255 wraps to 0), next FETCH.
REQ-024 PLAY with pause=1 -> PAUSED, beat_cnt frozen, note_valid=0; PAUSED with pause=0 -> PLAY, counting resumes from the frozen value.
REQ-025 pause SHALL be evaluated only in PLAY/PAUSED; pause raised during FETCH/WAIT takes effect on the first PLAY cycle.
REQ-026 stop=1 in any non-IDLE state SHALL force IDLE next cycle with note_valid=0 and no done pulse; stop has priority over start, pause, end-of-beat and end-marker.
REQ-027 beat_cnt SHALL be 24 bits; rom_addr arithmetic SHALL be 8-bit modulo.

Reset
REQ-028 On rst=1 at a clk edge the block SHALL enter IDLE with rom_addr=0, note_out=0, note_valid=0, busy=0, done=0, beat_cnt=0.
REQ-029 rst SHALL override all inputs, including mid-beat and PAUSED; rst asserted with start does not start playback.

Structure
REQ-030 A shared package beep_pkg SHALL hold the FSM state encoding, END_MARKER=8'hFF and REST_NOTE=8'h00.
REQ-031 The beat counter and gap compare SHALL be a sub-module beat_timer (inputs clear, enable; outputs cnt, beat_end, in_gap).
REQ-032 The block SHALL contain no combinational path from inputs to outputs; all outputs registered.

Verification (BEAT_CYCLES=8, GAP_CYCLES=2)
REQ-033 ROM {0:25, 1:27, 2:FF}; pulse start -> note_out 25 for 8 cycles, note_valid high 6 then low 2, then 27 likewise, done pulse after WAIT at address 2, busy low.
REQ-034 Same ROM, loop_en=1 -> after address 2, rom_addr returns to 0 and 25 replays; no done pulse.
REQ-035 ROM {0:25, 1:0, 2:FF} -> note_valid low for the whole beat at address 1, note_out=0.
REQ-036 pause high 3 cycles at beat_cnt=4 -> note_valid low 3 cycles; beat lasts 11 cycles total; next fetch at address 1.
REQ-037 stop at beat_cnt=3 of address 1, simultaneous with pause -> IDLE next cycle, note_valid=0, done never asserted; later start replays from address 0.
REQ-038 ROM full of 25, loop_en=0 -> after address 255 beat, done pulse, rom_addr not advanced past 255; rst asserted mid-beat -> all outputs at REQ-028 values next cycle.
